// File: rtl/alu_seq_unit.sv
// Registered EX-stage execute unit: single-cycle integer ALU ops with one-cycle
// latency, plus an iterative shift-add multiplier (MUL/MULHU) behind o_ready.
module alu_seq_unit #(
  parameter int DATA_W  = 32,
  parameter int OPER_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [OPER_W-1:0] i_oper,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);
  localparam int SHAMT_W = $clog2(DATA_W);

  localparam logic [OPER_W-1:0] OP_ADD   = OPER_W'(0);
  localparam logic [OPER_W-1:0] OP_SUB   = OPER_W'(1);
  localparam logic [OPER_W-1:0] OP_SLT   = OPER_W'(2);
  localparam logic [OPER_W-1:0] OP_SLTU  = OPER_W'(3);
  localparam logic [OPER_W-1:0] OP_XOR   = OPER_W'(4);
  localparam logic [OPER_W-1:0] OP_OR    = OPER_W'(5);
  localparam logic [OPER_W-1:0] OP_AND   = OPER_W'(6);
  localparam logic [OPER_W-1:0] OP_SLL   = OPER_W'(7);
  localparam logic [OPER_W-1:0] OP_SRL   = OPER_W'(8);
  localparam logic [OPER_W-1:0] OP_SRA   = OPER_W'(9);
  localparam logic [OPER_W-1:0] OP_LUI   = OPER_W'(10);
  localparam logic [OPER_W-1:0] OP_MUL   = OPER_W'(11);
  localparam logic [OPER_W-1:0] OP_MULHU = OPER_W'(12);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [2*DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]     mplier_q, mplier_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0]    cnt_q, cnt_d;
  logic                  hi_q, hi_d;
  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     data_q, data_d;

  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_W-1:0]     alu_res;
  logic                  is_mul;

  assign shamt  = i_op_b[SHAMT_W-1:0];
  assign is_mul = (i_oper == OP_MUL) || (i_oper == OP_MULHU);

  always_comb begin
    alu_res = '0;
    case (i_oper)
      OP_ADD:  alu_res = i_op_a + i_op_b;
      OP_SUB:  alu_res = i_op_a - i_op_b;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (i_op_a < i_op_b)};
      OP_XOR:  alu_res = i_op_a ^ i_op_b;
      OP_OR:   alu_res = i_op_a | i_op_b;
      OP_AND:  alu_res = i_op_a & i_op_b;
      OP_SLL:  alu_res = i_op_a << shamt;
      OP_SRL:  alu_res = i_op_a >> shamt;
      OP_SRA:  alu_res = $signed(i_op_a) >>> shamt;
      OP_LUI:  alu_res = i_op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    o_ready  = (state_q == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (is_mul) begin
            mcand_d  = {{DATA_W{1'b0}}, i_op_a};
            mplier_d = i_op_b;
            acc_d    = '0;
            cnt_d    = '0;
            hi_d     = (i_oper == OP_MULHU);
            state_d  = S_MUL;
          end else begin
            valid_d = 1'b1;
            data_d  = alu_res;
          end
        end
      end
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // cnt wraps to zero on the last iteration, which is harmless
        if (cnt_q == SHAMT_W'(DATA_W-1)) state_d = S_DONE;
      end
      S_DONE: begin
        valid_d = 1'b1;
        data_d  = hi_q ? acc_q[2*DATA_W-1:DATA_W] : acc_q[DATA_W-1:0];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: a timing/arithmetic model checked every
// cycle on a 32-bit instance, literal expectations, and a 16-bit instance.
module tb_alu_seq_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [4:0]  oper;
  logic [31:0] a, b;
  logic        rdy, ovld;
  logic [31:0] odata;

  logic        vld16;
  logic [4:0]  oper16;
  logic [15:0] a16, b16;
  logic        rdy16, ovld16;
  logic [15:0] odata16;

  int n_chk  = 0;
  int n_fail = 0;

  // model state: cycles the unit remains busy, and the pending multiply result
  int          m_busy;
  logic        m_valid;
  logic [31:0] m_data, m_pend;
  logic [31:0] lit_q[$];

  always #5 clk = ~clk;

  alu_seq_unit #(.DATA_W(32), .OPER_W(5)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(vld), .o_ready(rdy), .i_oper(oper),
    .i_op_a(a), .i_op_b(b), .o_valid(ovld), .o_data(odata));

  alu_seq_unit #(.DATA_W(16), .OPER_W(5)) dut16 (
    .i_clk(clk), .i_reset(rst), .i_valid(vld16), .o_ready(rdy16), .i_oper(oper16),
    .i_op_a(a16), .i_op_b(b16), .o_valid(ovld16), .o_data(odata16));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] x, input logic [31:0] y);
    int s;
    logic [31:0] r;
    s = int'(y & 32'd31);
    case (op)
      0:  return x + y;
      1:  return x - y;
      2:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3:  return (x < y) ? 32'd1 : 32'd0;
      4:  return x ^ y;
      5:  return x | y;
      6:  return x & y;
      7:  return x << s;
      8:  return x >> s;
      9: begin
        r = x >> s;
        if (x[31]) r = r | ~(32'hFFFF_FFFF >> s);
        return r;
      end
      10: return y;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [63:0] p;
    if (rst) begin
      m_busy = 0; m_valid = 1'b0; m_data = '0;
    end else begin
      m_valid = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin m_valid = 1'b1; m_data = m_pend; end
      end else if (vld) begin
        if (oper == 5'd11 || oper == 5'd12) begin
          p = {32'd0, a} * {32'd0, b};
          m_pend = (oper == 5'd12) ? p[63:32] : p[31:0];
          m_busy = 33;
        end else begin
          m_valid = 1'b1;
          m_data  = ref_alu(int'(oper), a, b);
        end
      end
    end
  endtask

  // model advances on each edge; DUT outputs are compared 1 time unit later
  initial begin
    m_busy = 0; m_valid = 1'b0; m_data = '0; m_pend = '0;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("ready", rdy, (m_busy == 0));
      check("valid", ovld, m_valid);
      check("data", odata, m_data);
      if (ovld && lit_q.size() > 0) check("literal", odata, lit_q.pop_front());
    end
  end

  task automatic send(input int op, input logic [31:0] x, input logic [31:0] y);
    logic r;
    int n;
    @(negedge clk);
    vld = 1'b1; oper = 5'(op); a = x; b = y;
    n = 0;
    do begin
      r = rdy;
      @(posedge clk);
      n++;
    end while (!r && n < 100);
    if (!r) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: got ready=0 after %0d cycles, required ready=1", n);
    end
  endtask

  task automatic sendl(input int op, input logic [31:0] x, input logic [31:0] y, input logic [31:0] lit);
    lit_q.push_back(lit);
    send(op, x, y);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic run16(input string name, input int op, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] exp, input int lat);
    int n;
    @(negedge clk);
    check({name, "_rdy"}, rdy16, 1'b1);
    vld16 = 1'b1; oper16 = 5'(op); a16 = x; b16 = y;
    @(posedge clk);
    #1;
    vld16 = 1'b0;
    n = 0;
    while (!ovld16 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_lat"}, n, lat);
    check({name, "_data"}, odata16, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int r, op;
    rst = 1'b1; vld = 1'b0; oper = '0; a = '0; b = '0;
    vld16 = 1'b0; oper16 = '0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_data", odata, 32'd0);
    check("rst_valid", ovld, 1'b0);
    check("rst_ready", rdy, 1'b1);

    sendl(0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    sendl(1, 32'h0, 32'h1, 32'hFFFF_FFFF);
    idle(1);
    // back-to-back single-cycle stream
    sendl(9, 32'h8000_0000, 32'h24, 32'hF800_0000);
    sendl(8, 32'h8000_0000, 32'h24, 32'h0800_0000);
    sendl(7, 32'h8000_0000, 32'h24, 32'h0000_0000);
    sendl(2, 32'hFFFF_FFFF, 32'h1, 32'h1);
    sendl(3, 32'hFFFF_FFFF, 32'h1, 32'h0);
    sendl(10, 32'h1234_5678, 32'hABCD_1234, 32'hABCD_1234);
    sendl(5, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF);
    sendl(6, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030);
    idle(1);
    sendl(11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    sendl(12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    sendl(11, 32'h1234_5678, 32'h0, 32'h0);
    // ADD held while the multiply is busy, accepted in its result cycle
    sendl(11, 32'd6, 32'd7, 32'd42);
    sendl(0, 32'd3, 32'd4, 32'd7);
    idle(2);
    // reset 10 cycles into a multiply aborts it
    send(12, 32'hDEAD_BEEF, 32'h1234_5678);
    idle(9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_data", odata, 32'd0);
    check("abort_ready", rdy, 1'b1);
    check("abort_valid", ovld, 1'b0);
    sendl(4, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0);
    sendl(15, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);
    idle(40);
    check("lit_drain", lit_q.size(), 0);

    run16("w16_mulhu", 12, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17);
    run16("w16_sra", 9, 16'h8000, 16'h0013, 16'hF000, 0);
    run16("w16_mul", 11, 16'h00FF, 16'h0101, 16'hFFFF, 17);

    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 19);
      op = (r < 13) ? r : $urandom_range(13, 31);
      send(op, pick(), pick());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end
    idle(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised, registered execute unit that succeeds the combinational ALU result selector.
- Computes all base integer ALU operations internally with one-cycle registered latency.
- Adds an iterative shift-add multiplier (MUL/MULHU) with a valid/ready input handshake.
- Sits in the EX stage; o_ready feeds the pipeline stall logic.

Parameters:
- DATA_W, 32, operand/result width (>=8, power of 2).
- SHAMT_W, $clog2(DATA_W), shift-amount width (derived, not overridden).
- OPER_W, 5, operation code width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous active-high reset.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request this cycle.
- i_oper  in  OPER_W  operation code.
- i_op_a  in  DATA_W  operand A.
- i_op_b  in  DATA_W  operand B.
- o_valid  out  1  one-cycle result strobe.
- o_data  out  DATA_W  result; holds its last value while o_valid=0.

Behaviour:
- Single clock, i_clk. Reset is synchronous and active-high on i_reset.
- Reset values: state=IDLE, o_valid=0, o_data=0, o_ready=1, internal accumulator/counter=0.
- Accept condition: i_valid & o_ready at a rising edge. i_valid while o_ready=0 is ignored; the requester holds it.
- Opcodes:
  - 0 ADD: a+b, modulo 2^DATA_W.
  - 1 SUB: a-b.
  - 2 SLT: signed a<b gives 1, else 0.
  - 3 SLTU: unsigned a<b.
  - 4 XOR, 5 OR, 6 AND.
  - 7 SLL: a << b[SHAMT_W-1:0].
  - 8 SRL: logical right shift.
  - 9 SRA: arithmetic right shift.
  - 10 LUI: pass b.
  - 11 MUL: low DATA_W bits of unsigned a*b.
  - 12 MULHU: high DATA_W bits of unsigned a*b.
  - Any other code: result 0, with normal one-cycle timing.
- Single-cycle ops (all except 11/12): accepted at edge T; o_data/o_valid are registered at edge T, so o_valid=1 in the cycle following T, for exactly one cycle. o_ready stays 1, so back-to-back issue gives a 1-per-cycle result stream.
- FSM states:
  - IDLE: o_ready=1. Accepting op 11/12 loads multiplicand=a (zero-extended to 2*DATA_W), multiplier=b, acc=0, cnt=0, latches the hi/lo select, and goes to MUL.
  - MUL: o_ready=0. Each edge:
    - if multiplier[0], acc += multiplicand;
    - multiplicand <<= 1; multiplier >>= 1; cnt++.
    - When cnt reaches DATA_W-1 (the final iteration edge), go to DONE.
  - DONE: one cycle. At its edge, o_data = acc[DATA_W-1:0] (MUL) or acc[2*DATA_W-1:DATA_W] (MULHU), o_valid=1, next state IDLE.
- Multiply timing: accept at edge T; o_valid high in the cycle after edge T+DATA_W+1. o_ready is low for DATA_W+1 cycles and returns high in the same cycle o_valid pulses. A new request may therefore be accepted in the result cycle.
- While a multiply is in flight, no other result is produced and o_data is unchanged until completion.
- Reset mid-multiply: the operation is aborted, no o_valid pulse ever occurs for it, and outputs go to their reset values.
- o_valid is never high for two consecutive cycles from a single request. No output backpressure: the consumer must take the result on the strobe.
- Shift amount uses only the low SHAMT_W bits of b; upper bits are ignored.

Test Plan:
1. DATA_W=32, ADD 0x7FFFFFFF+0x00000001 -> o_data=0x80000000, o_valid one cycle after accept. SUB 0x0-0x1 -> 0xFFFFFFFF.
2. a=0x80000000, b=0x24 (shamt 4): SRA -> 0xF8000000, SRL -> 0x08000000, SLL -> 0x00000000. SLT(0xFFFFFFFF,1) -> 1; SLTU(0xFFFFFFFF,1) -> 0. Issue all back-to-back: one result per cycle, o_ready constantly 1.
3. MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001, and MULHU -> 0xFFFFFFFE. o_valid exactly 33 cycles after accept, o_ready low for 33 cycles. Also MUL 0x12345678*0 -> 0.
4. During a MUL, hold i_valid=1 with ADD 3+4 -> ignored until o_ready rises. The ADD is accepted in the MUL result cycle, and o_data=7 is strobed the next cycle (two consecutive strobes, distinct results).
5. Assert i_reset for one cycle 10 cycles into a MUL -> no o_valid afterwards, o_data=0, o_ready=1. A following XOR 0xF0F0F0F0^0xFFFF0000 -> 0x0F0FF0F0.
6. i_oper=15 -> o_data=0 with o_valid after 1 cycle. DATA_W=16 build: MULHU 0xFFFF*0xFFFF -> 0xFFFE with o_valid 17 cycles after accept; SRA 0x8000 by b=0x13 (shamt 3) -> 0xF000.
